// File: rtl/led_mode_select.sv
`default_nettype none
// ============================================================================
// Module   : led_mode_select
// Purpose  : Debounced push-button mode selector. Each accepted press advances
//            a 2-bit mode index. One of four LED patterns drives the outputs,
//            and the LEDs are blanked for a short window after every change.
// Revision : 1.0 - initial release
// ============================================================================
module led_mode_select #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int BLANK_CYCLES    = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_n,
   input  logic [7:0] mode0_led,
   input  logic [7:0] mode1_led,
   input  logic [7:0] mode2_led,
   input  logic [7:0] mode3_led,
   output logic [7:0] led_out,
   output logic [1:0] mode_sel,
   output logic       mode_changed
);

   localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
   localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK_CYCLES);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   logic               key_meta;
   logic               key_s;
   logic               pressed;
   state_t             state;
   state_t             state_nxt;
   logic [DEB_W-1:0]   deb_cnt;
   logic [DEB_W-1:0]   deb_cnt_nxt;
   logic               advance;
   logic [BLANK_W-1:0] blank_cnt;
   logic [7:0]         sel_led;

   assign pressed = ~key_s;

   // Two-flop synchronizer for the asynchronous button; resets to "released".
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_meta <= 1'b1;
         key_s    <= 1'b1;
      end else begin
         key_meta <= key_n;
         key_s    <= key_meta;
      end
   end

   // Debounce state register and stability counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         deb_cnt <= '0;
      end else begin
         state   <= state_nxt;
         deb_cnt <= deb_cnt_nxt;
      end
   end

   // Debounce next-state logic; advance fires once when a press is confirmed.
   always_comb begin
      state_nxt   = state;
      deb_cnt_nxt = '0;
      advance     = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) begin
               state_nxt   = PRESS_WAIT;
               deb_cnt_nxt = DEB_W'(1);
            end
         end
         PRESS_WAIT: begin
            if (!pressed) begin
               state_nxt = IDLE;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = HELD;
               advance   = 1'b1;
            end else begin
               deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end
         end
         HELD: begin
            // Holding the key never re-arms the advance: no auto-repeat.
            if (!pressed) begin
               state_nxt   = RELEASE_WAIT;
               deb_cnt_nxt = DEB_W'(1);
            end
         end
         RELEASE_WAIT: begin
            // A press seen here is release bounce; return to HELD silently.
            if (pressed) begin
               state_nxt = HELD;
            end else if (deb_cnt == DEB_LAST) begin
               state_nxt = IDLE;
            end else begin
               deb_cnt_nxt = deb_cnt + DEB_W'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Pattern multiplexer driven by the current mode index.
   always_comb begin
      sel_led = mode0_led;
      case (mode_sel)
         2'd0:    sel_led = mode0_led;
         2'd1:    sel_led = mode1_led;
         2'd2:    sel_led = mode2_led;
         default: sel_led = mode3_led;
      endcase
   end

   // Mode index, change pulse, blanking window and registered LED drive.
   // A new advance reloads the blank window rather than extending it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_sel     <= 2'd0;
         mode_changed <= 1'b0;
         blank_cnt    <= '0;
         led_out      <= 8'h00;
      end else begin
         mode_changed <= advance;
         if (advance) begin
            mode_sel  <= mode_sel + 2'd1;
            blank_cnt <= BLANK_LOAD;
         end else if (blank_cnt != '0) begin
            blank_cnt <= blank_cnt - BLANK_W'(1);
         end
         led_out <= (blank_cnt != '0) ? 8'h00 : sel_led;
      end
   end

endmodule
`default_nettype wire

// File: doc/led_mode_select.md
LED_MODE_SELECT -- requirements
Module: led_mode_select

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 20000, which sets the number of consecutive stable synchronized samples needed to accept a key edge; legal values are 2 or more.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 1000, which sets the number of cycles led_out is forced to 0 after a mode change; legal values are 1 or more.
REQ-003 clk  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 key_n  input  1  raw mode-select push button, active-low, asynchronous to clk.
REQ-006 mode0_led, mode1_led, mode2_led, mode3_led  input  8 each  LED patterns from the four mode drivers.
REQ-007 led_out  output  8  registered LED drive to the board pins.
REQ-008 mode_sel  output  2  current mode index.
REQ-009 mode_changed  output  1  one-cycle pulse on each accepted mode advance.

Function
REQ-010 key_n SHALL pass through a 2-flop synchronizer, and the synchronized value is key_s; pressed means key_s = 0.
REQ-011 The debounce FSM SHALL have states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter deb_cnt of ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-012 IDLE SHALL behave as follows:
- key pressed: go to PRESS_WAIT with deb_cnt = 1.
- otherwise: stay in IDLE with deb_cnt = 0.
REQ-013 PRESS_WAIT SHALL behave as follows:
- key released: go to IDLE with deb_cnt = 0; glitch rejected.
- key pressed and deb_cnt = DEBOUNCE_CYCLES-1: go to HELD and assert the advance strobe for 1 cycle.
- key pressed otherwise: deb_cnt increments.
REQ-014 HELD SHALL behave as follows:
- key released: go to RELEASE_WAIT with deb_cnt = 1.
- holding the key indefinitely: no further advance (no auto-repeat).
REQ-015 RELEASE_WAIT SHALL behave as follows:
- key pressed: go to HELD with no advance; release bounce is ignored.
- key released and deb_cnt = DEBOUNCE_CYCLES-1: go to IDLE.
- key released otherwise: deb_cnt increments.
REQ-016 On the advance strobe, the cycle after it:
- mode_sel increments modulo 4 (3 wraps to 0).
- mode_changed = 1 for exactly that cycle.
- blank_cnt is loaded with BLANK_CYCLES.
REQ-017 While blank_cnt is nonzero:
- led_out SHALL be 8'h00.
- blank_cnt SHALL decrement by 1 per cycle, so led_out is 0 for exactly BLANK_CYCLES cycles.
REQ-018 While blank_cnt is zero, led_out SHALL register modeN_led selected by mode_sel, with a latency of 1 cycle from the input change to led_out.
REQ-019 If an advance occurs while blanking, blank_cnt SHALL reload to BLANK_CYCLES; the window restarts and does not accumulate.
REQ-020 Unused codes SHALL NOT exist: mode_sel is 2 bits and all 4 values are valid. An illegal FSM encoding SHALL recover to IDLE on the next cycle.

Reset
REQ-021 With rst_n = 0 the following SHALL take effect asynchronously: synchronizer flops = 1 (released), FSM = IDLE, deb_cnt = 0, mode_sel = 0, blank_cnt = 0, mode_changed = 0, led_out = 8'h00.
REQ-022 Asserting reset mid-debounce or mid-blank SHALL abort the operation with no pending advance. After rst_n deasserts, led_out SHALL follow mode0_led from the first clock edge; no blank occurs.
REQ-023 A key held through reset release SHALL be treated as a new press: PRESS_WAIT, then one advance after DEBOUNCE_CYCLES stable samples.

Verification
All scenarios use DEBOUNCE_CYCLES = 4 and BLANK_CYCLES = 3.
REQ-024 Clean press:
- Stimulus: mode0_led = 8'hA5, mode1_led = 8'h3C; hold key_n = 0 for 20 cycles.
- Response: exactly one mode_changed pulse and mode_sel = 1; led_out = 0 for 3 cycles, then 8'h3C.
REQ-025 Glitch rejection: key_n = 0 for 3 cycles, then 1 -> no advance, mode_sel stays 0, led_out stays 8'hA5.
REQ-026 Bounce on release:
- Stimulus: press accepted, then key_n toggles 1/0 every 2 cycles for 10 cycles, then stays high.
- Response: a single advance only; FSM returns to IDLE 4 cycles after the final release.
REQ-027 Wrap-around: four clean presses -> mode_sel sequence 1, 2, 3, 0 and four mode_changed pulses; led_out ends equal to mode0_led.
REQ-028 Reset mid-blank: assert rst_n during the second blank cycle -> mode_sel = 0 and led_out = 0 immediately; after release, led_out = mode0_led on the next clock edge.
REQ-029 Pass-through latency: with mode_sel = 2, change mode2_led from 8'h01 to 8'h80 -> led_out = 8'h80 exactly 1 clock later.
